dispatch_queue: RTL and testbench
=================================

// Module: dispatch_queue
// PURPOSE
//  In-order, 4-wide circular instruction buffer between rename and the reservation station (rs).
//  Accepts up to 4 renamed bundles per cycle and presents the oldest 4 to rs as a contiguous valid group.
//  Retires the number rs reports as dispatched; dispatch is in order, so retirement is always from the head.
//  Decouples rename from rs stalls.
// PARAMETERS
//  BWIDTH  57  bundle width in bits; opaque payload passed through unmodified
//  DEPTH   16  entry count; power of two, >= 8
//  PBITS   $clog2(DEPTH)  pointer width (derived, localparam)
// PORTS
//  i_clk            in   1            clock
//  i_rst            in   1            reset, asynchronous, active-high
//  i_flush          in   1            discard all entries (branch mispredict / exception)
//  i_enq_bundle0-3  in   BWIDTH each  bundles from rename; bundle0 is oldest
//  i_enq_valid      in   4            enqueue request per bundle
//  o_enq_ready      out  1            high when at least 4 entries are free
//  o_ins_bundle0-3  out  BWIDTH each  head..head+3 entries, to rs i_ins_bundle0-3
//  o_ins_valid      out  4            thermometer code: bit k = (count > k)
//  i_deq_count      in   3            bundles rs accepted this cycle (0-4)
//  o_count          out  PBITS+1      current occupancy
//  o_empty          out  1            count == 0
//  o_full           out  1            count == DEPTH
// BEHAVIOUR
//  - Storage: DEPTH x BWIDTH array; head and tail pointers of PBITS bits.
//    - Pointers wrap modulo DEPTH through natural overflow.
//    - Entry at address (head+k) mod DEPTH drives o_ins_bundle{k}.
//  - Enqueue count n_enq is the run of consecutive 1s in i_enq_valid starting at bit 0.
//    - 4'b0111 gives n_enq = 3; 4'b1011 gives n_enq = 2 (bits above the first 0 are ignored).
//    - When o_enq_ready = 0, n_enq = 0 and nothing is written.
//  - Enqueue is all-or-nothing. o_enq_ready = (count <= DEPTH-4), from registered count only.
//    - There is no combinational path from i_deq_count or i_enq_valid to o_enq_ready.
//  - Enqueue write: bundle k goes to (tail+k) mod DEPTH for k < n_enq; tail += n_enq.
//  - Dequeue count n_deq = min(i_deq_count, number of valid outputs). Excess requests are clamped, not an error.
//    - head += n_deq.
//  - Same-cycle enqueue and dequeue are both honoured: count_next = count + n_enq - n_deq.
//    - A dequeue never frees space for a same-cycle enqueue, because ready is decided from current count.
//  - Latency:
//    - An enqueued bundle appears on the outputs the cycle after its write edge. No bypass.
//    - Output ports are combinational reads of registered state.
//    - Entries at or beyond count are don't-care when not valid; o_ins_valid masks them.
//  - Wrap-around: a group of 4 may straddle the DEPTH-1 -> 0 boundary on both write and read,
//    with no bubble and no reordering.
//  - Flush (synchronous): the next cycle has head = tail = 0 and count = 0.
//    - Flush has priority over enqueue and dequeue in the same cycle; those requests are dropped.
//  - Reset (asynchronous, any cycle, including mid-burst): head = tail = count = 0 and storage is cleared to 0.
//    - Output values during reset: o_ins_valid = 0, o_ins_bundle* = 0, o_enq_ready = 1, o_empty = 1, o_full = 0, o_count = 0.
//  - Invariant: 0 <= count <= DEPTH; tail - head == count mod DEPTH.
//    - Formal asserts this invariant under `ifdef FORMAL.
// TESTING
//  1. Reset, then enqueue A,B,C,D with valid 4'b1111 and i_deq_count 0.
//     -> Next cycle: o_ins_valid = 4'b1111, outputs A..D, o_count = 4.
//  2. Fill to count 12, then present valid 4'b1111.
//     -> o_enq_ready = 1 and count becomes 16, o_full = 1.
//     -> On the next attempt o_enq_ready = 0 and count stays at 16.
//  3. With count 3 (valid 4'b0111), set i_deq_count = 4 and enqueue 2.
//     -> n_deq clamps to 3; the next cycle has count 2, o_ins_valid = 4'b0011, and the new bundles are in order.
//  4. Advance head to 14, then enqueue 4 and drain with i_deq_count 4.
//     -> The outputs show the 4 bundles in order across the wrap; count returns to 0.
//  5. With count 9, assert i_flush together with an enqueue of 4 and i_deq_count 2.
//     -> Next cycle: count 0, o_ins_valid 0, o_empty 1.
//  6. Pulse i_rst mid-stream with count 7.
//     -> Outputs go to reset values asynchronously; the first enqueue after release is readable at entry 0.

Source files
------------

// File: rtl/dispatch_queue.sv
// dispatch_queue: 4-wide in-order circular buffer between rename and the reservation station.
// Accepts up to four bundles per cycle and presents the oldest four as a contiguous valid group.
module dispatch_queue #(
  parameter int BWIDTH = 57,
  parameter int DEPTH  = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic [BWIDTH-1:0]      i_enq_bundle0,
  input  logic [BWIDTH-1:0]      i_enq_bundle1,
  input  logic [BWIDTH-1:0]      i_enq_bundle2,
  input  logic [BWIDTH-1:0]      i_enq_bundle3,
  input  logic [3:0]             i_enq_valid,
  output logic                   o_enq_ready,
  output logic [BWIDTH-1:0]      o_ins_bundle0,
  output logic [BWIDTH-1:0]      o_ins_bundle1,
  output logic [BWIDTH-1:0]      o_ins_bundle2,
  output logic [BWIDTH-1:0]      o_ins_bundle3,
  output logic [3:0]             o_ins_valid,
  input  logic [2:0]             i_deq_count,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_full
);

  localparam int PBITS = $clog2(DEPTH);
  localparam logic [PBITS:0] ENQ_LIMIT = (PBITS+1)'(DEPTH - 4);
  localparam logic [PBITS:0] GROUP_SZ  = (PBITS+1)'(4);
  localparam logic [PBITS:0] FULL_CNT  = (PBITS+1)'(DEPTH);

  logic [BWIDTH-1:0] mem_r [DEPTH];
  logic [PBITS-1:0]  head_r;
  logic [PBITS-1:0]  tail_r;
  logic [PBITS:0]    count_r;
  logic [PBITS:0]    count_nxt_s;
  logic [2:0]        n_enq_s;
  logic [2:0]        n_avail_s;
  logic [2:0]        n_deq_s;
  logic [BWIDTH-1:0] enq_bundle_s [4];
  logic [BWIDTH-1:0] ins_bundle_s [4];

  assign enq_bundle_s[0] = i_enq_bundle0;
  assign enq_bundle_s[1] = i_enq_bundle1;
  assign enq_bundle_s[2] = i_enq_bundle2;
  assign enq_bundle_s[3] = i_enq_bundle3;

  // Ready depends on registered occupancy only, so a same-cycle dequeue never frees room.
  assign o_enq_ready = (count_r <= ENQ_LIMIT);
  assign o_count     = count_r;
  assign o_empty     = (count_r == '0);
  assign o_full      = (count_r == FULL_CNT);

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_read
      assign ins_bundle_s[g] = mem_r[head_r + PBITS'(g)];
      assign o_ins_valid[g]  = (count_r > (PBITS+1)'(g));
    end
  endgenerate

  assign o_ins_bundle0 = ins_bundle_s[0];
  assign o_ins_bundle1 = ins_bundle_s[1];
  assign o_ins_bundle2 = ins_bundle_s[2];
  assign o_ins_bundle3 = ins_bundle_s[3];

  // Enqueue count is the run of leading valids from bit 0; bits past the first gap are ignored.
  always_comb begin
    n_enq_s = 3'd0;
    if (!o_enq_ready) begin
      n_enq_s = 3'd0;
    end else begin
      casez (i_enq_valid)
        4'b???0: n_enq_s = 3'd0;
        4'b??01: n_enq_s = 3'd1;
        4'b?011: n_enq_s = 3'd2;
        4'b0111: n_enq_s = 3'd3;
        4'b1111: n_enq_s = 3'd4;
        default: n_enq_s = 3'd0;
      endcase
    end
  end

  // Dequeue request is clamped to the number of entries currently presented.
  always_comb begin
    n_avail_s = 3'd0;
    if (count_r >= GROUP_SZ) begin
      n_avail_s = 3'd4;
    end else begin
      n_avail_s = count_r[2:0];
    end
    n_deq_s     = (i_deq_count < n_avail_s) ? i_deq_count : n_avail_s;
    count_nxt_s = count_r + (PBITS+1)'(n_enq_s) - (PBITS+1)'(n_deq_s);
  end

  // Storage: cleared on reset, written at tail+k; a flush leaves contents untouched but unreachable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (!i_flush) begin
      for (int k = 0; k < 4; k++) begin
        if (k < int'(n_enq_s)) begin
          mem_r[tail_r + PBITS'(k)] <= enq_bundle_s[k];
        end
      end
    end
  end

  // Pointer and occupancy registers; flush wins over same-cycle enqueue and dequeue.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (i_flush) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      head_r  <= head_r + PBITS'(n_deq_s);
      tail_r  <= tail_r + PBITS'(n_enq_s);
      count_r <= count_nxt_s;
    end
  end

`ifdef FORMAL
  dispatch_queue_checker #(.DEPTH(DEPTH)) u_checker (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .head    (head_r),
    .tail    (tail_r),
    .count   (count_r)
  );
`endif

endmodule

`ifdef FORMAL
// Occupancy invariant: count bounded by DEPTH and consistent with the pointer distance.
module dispatch_queue_checker #(
  parameter int DEPTH = 16
) (
  input logic                       i_clk,
  input logic                       i_rst,
  input logic [$clog2(DEPTH)-1:0]   head,
  input logic [$clog2(DEPTH)-1:0]   tail,
  input logic [$clog2(DEPTH):0]     count
);
  localparam int PBITS = $clog2(DEPTH);

  // Checked every cycle outside reset.
  always @(posedge i_clk) begin
    if (!i_rst) begin
      assert (count <= (PBITS+1)'(DEPTH));
      assert (PBITS'(tail - head) == count[PBITS-1:0]);
    end
  end
endmodule
`endif

// File: tb/tb_dispatch_queue.sv
// Directed scoreboard bench for dispatch_queue: a model queue holds the expected entries in order
// and every cycle the presented group, valid mask and occupancy flags are compared against it.
module tb_dispatch_queue;
  localparam int BW = 57;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic [BW-1:0] eb0 = '0, eb1 = '0, eb2 = '0, eb3 = '0;
  logic [3:0]    ev = 4'd0;
  logic [2:0]    dc = 3'd0;
  logic          rdy;
  logic [BW-1:0] ob0, ob1, ob2, ob3;
  logic [3:0]    ov;
  logic [4:0]    cnt;
  logic          emp, ful;

  int            tests = 0;
  int            fails = 0;
  int            seq   = 1;
  logic [BW-1:0] mq[$];

  always #5 clk = ~clk;

  dispatch_queue #(.BWIDTH(BW), .DEPTH(DP)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_flush       (flush),
    .i_enq_bundle0 (eb0),
    .i_enq_bundle1 (eb1),
    .i_enq_bundle2 (eb2),
    .i_enq_bundle3 (eb3),
    .i_enq_valid   (ev),
    .o_enq_ready   (rdy),
    .o_ins_bundle0 (ob0),
    .o_ins_bundle1 (ob1),
    .o_ins_bundle2 (ob2),
    .o_ins_bundle3 (ob3),
    .o_ins_valid   (ov),
    .i_deq_count   (dc),
    .o_count       (cnt),
    .o_empty       (emp),
    .o_full        (ful)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, 64'(ov), 64'd0);
    chk({tag, "_b0"}, 64'(ob0), 64'd0);
    chk({tag, "_b1"}, 64'(ob1), 64'd0);
    chk({tag, "_b2"}, 64'(ob2), 64'd0);
    chk({tag, "_b3"}, 64'(ob3), 64'd0);
    chk({tag, "_ready"}, 64'(rdy), 64'd1);
    chk({tag, "_empty"}, 64'(emp), 64'd1);
    chk({tag, "_full"}, 64'(ful), 64'd0);
    chk({tag, "_count"}, 64'(cnt), 64'd0);
  endtask

  task automatic check_outputs(input string tag);
    logic [BW-1:0] obs [4];
    logic [3:0]    vexp;
    int            sz;
    sz = mq.size();
    obs[0] = ob0; obs[1] = ob1; obs[2] = ob2; obs[3] = ob3;
    for (int k = 0; k < 4; k++) vexp[k] = (sz > k);
    chk({tag, "_count"}, 64'(cnt), 64'(sz));
    chk({tag, "_empty"}, 64'(emp), 64'(sz == 0));
    chk({tag, "_full"}, 64'(ful), 64'(sz == DP));
    chk({tag, "_valid"}, 64'(ov), 64'(vexp));
    for (int k = 0; k < 4 && k < sz; k++) begin
      chk($sformatf("%s_bundle%0d", tag, k), 64'(obs[k]), 64'(mq[k]));
    end
  endtask

  // One clock of stimulus: drive at negedge, predict, update the scoreboard, check after the edge.
  task automatic cycle(input string tag, input logic [3:0] v, input int d, input logic f);
    logic [BW-1:0] nb [4];
    int            ne, nv, nd;
    bit            ready;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      nb[k] = {seq[24:0], $urandom()};
      seq++;
    end
    eb0 = nb[0]; eb1 = nb[1]; eb2 = nb[2]; eb3 = nb[3];
    ev = v; dc = 3'(d); flush = f;
    ready = (mq.size() <= DP - 4);
    chk({tag, "_ready"}, 64'(rdy), 64'(ready));
    ne = 0;
    if (ready) begin
      while (ne < 4 && v[ne] == 1'b1) ne++;
    end
    nv = (mq.size() < 4) ? mq.size() : 4;
    nd = (d < nv) ? d : nv;
    @(posedge clk);
    if (f) begin
      mq.delete();
    end else begin
      repeat (nd) void'(mq.pop_front());
      for (int k = 0; k < ne; k++) mq.push_back(nb[k]);
    end
    #1;
    ev = 4'd0; dc = 3'd0; flush = 1'b0;
    check_outputs(tag);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 check_reset_vals("rst0");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic 4-wide enqueue
    cycle("t1_enq4", 4'b1111, 0, 1'b0);

    // Fill to 12, then to 16, then a rejected attempt
    cycle("t2_fill8", 4'b1111, 0, 1'b0);
    cycle("t2_fill12", 4'b1111, 0, 1'b0);
    cycle("t2_fill16", 4'b1111, 0, 1'b0);
    cycle("t2_reject", 4'b1111, 0, 1'b0);
    cycle("t2_deq_enq_full", 4'b1111, 3, 1'b0);
    repeat (4) cycle("t2_drain", 4'b0000, 4, 1'b0);

    // Dequeue clamp with same-cycle enqueue
    cycle("t3_enq3", 4'b0111, 0, 1'b0);
    cycle("t3_clamp", 4'b0011, 4, 1'b0);
    cycle("t3_drain", 4'b0000, 4, 1'b0);

    // Move head to 14 and straddle the wrap; 4'b1011 enqueues only two
    cycle("t4_flush", 4'b0000, 0, 1'b1);
    repeat (3) begin
      cycle("t4_adv_enq", 4'b1111, 0, 1'b0);
      cycle("t4_adv_deq", 4'b0000, 4, 1'b0);
    end
    cycle("t4_enq_gap", 4'b1011, 0, 1'b0);
    cycle("t4_deq2", 4'b0000, 2, 1'b0);
    cycle("t4_wrap_enq", 4'b1111, 0, 1'b0);
    cycle("t4_wrap_deq", 4'b0000, 4, 1'b0);

    // Flush beats same-cycle enqueue and dequeue
    cycle("t5_enq4a", 4'b1111, 0, 1'b0);
    cycle("t5_enq4b", 4'b1111, 1, 1'b0);
    cycle("t5_enq2", 4'b0011, 0, 1'b0);
    cycle("t5_flush", 4'b1111, 2, 1'b1);

    // Asynchronous reset mid-stream
    cycle("t6_enq4", 4'b1111, 0, 1'b0);
    cycle("t6_enq3", 4'b0111, 0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_vals("t6_async");
    @(posedge clk);
    #1 check_reset_vals("t6_hold");
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    cycle("t6_after", 4'b1111, 0, 1'b0);
    cycle("t6_idle", 4'b0000, 1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
